// File: rtl/alu_cmd_seq_if.sv
// Bundle of command, ALU-drive and response signals for alu_cmd_seq.
// slave = sequencer side, master = datapath control / ALU / consumer side.
interface alu_cmd_seq_if #(
  parameter int W = 32
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;

  logic [W-1:0] alu_in0;
  logic [W-1:0] alu_in1;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_out;
  logic         alu_carryout;
  logic         alu_overflow;
  logic         alu_zero;
  logic         alu_n;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [3:0]   rsp_flags;
  logic         rsp_err;

  logic         trap;
  logic         trap_clr;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  alu_out, alu_carryout, alu_overflow, alu_zero, alu_n,
    input  rsp_ready, trap_clr,
    output cmd_ready, alu_in0, alu_in1, alu_op,
    output rsp_valid, rsp_data, rsp_flags, rsp_err, trap
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output alu_out, alu_carryout, alu_overflow, alu_zero, alu_n,
    output rsp_ready, trap_clr,
    input  cmd_ready, alu_in0, alu_in1, alu_op,
    input  rsp_valid, rsp_data, rsp_flags, rsp_err, trap
  );
endinterface

// File: rtl/alu_cmd_seq.sv
// Command sequencer wrapping the combinational 32-bit add/sub ALU behind valid/ready channels.
// Optional sticky overflow trap enabled by defining ALU_OVF_TRAP_EN.
module alu_cmd_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_cmd_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] in0_q, in0_d;
  logic [W-1:0] in1_q, in1_d;
  logic [3:0]   op_q, op_d;
  logic [W-1:0] data_q, data_d;
  logic [3:0]   flags_q, flags_d;
  logic         err_q, err_d;
  logic         trap_q, trap_d;

  logic cmd_ready;
  logic op_legal;

  assign op_legal  = (bus.cmd_op[3:2] == 2'b00);
  assign cmd_ready = (state_q == IDLE) && !trap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      in0_q   <= '0;
      in1_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
      op_q    <= op_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      err_q   <= err_d;
      trap_q  <= trap_d;
    end
  end

  // The ALU drive registers double as the command latch, so an illegal op leaves them untouched.
  always_comb begin
    state_d = state_q;
    in0_d   = in0_q;
    in1_d   = in1_q;
    op_d    = op_q;
    data_d  = data_q;
    flags_d = flags_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          if (op_legal) begin
            in0_d   = bus.cmd_a;
            in1_d   = bus.cmd_b;
            op_d    = bus.cmd_op;
            state_d = ISSUE;
          end else begin
            data_d  = '0;
            flags_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ISSUE: begin
        data_d  = bus.alu_out;
        flags_d = {bus.alu_n, bus.alu_zero, bus.alu_carryout, bus.alu_overflow};
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_OVF_TRAP_EN
  // Set has priority over a simultaneous clear.
  always_comb begin
    trap_d = trap_q;
    if (bus.trap_clr) begin
      trap_d = 1'b0;
    end
    if ((state_q == ISSUE) && bus.alu_overflow) begin
      trap_d = 1'b1;
    end
  end
`else
  logic unused_trap_clr;
  assign unused_trap_clr = bus.trap_clr;

  always_comb begin
    trap_d = 1'b0;
  end
`endif

  assign bus.cmd_ready = cmd_ready;
  assign bus.alu_in0   = in0_q;
  assign bus.alu_in1   = in1_q;
  assign bus.alu_op    = op_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_flags = flags_q;
  assign bus.rsp_err   = err_q;
  assign bus.trap      = trap_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Randomized self-checking bench for alu_cmd_seq with a behavioural ALU and reference model.
module tb_alu_cmd_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_seq_if #(.W(W)) bus ();

  alu_cmd_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  f;   // {N,Z,C,V}
  } alu_res_t;

  // Behavioural add/sub ALU; ops 1 and 3 use a constant 1 as second operand.
  function automatic alu_res_t alu_fn(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    alu_res_t    o;
    logic [32:0] s;
    logic [31:0] bb;
    logic        v;
    if (op[3:2] != 2'b00) begin
      o.r = 32'hDEAD_BEEF;
      o.f = 4'hF;
      return o;
    end
    bb = op[0] ? 32'd1 : b;
    if (op[1]) begin
      s = {1'b0, a} + {1'b0, ~bb} + 33'd1;
      o.r = s[31:0];
      v = (a[31] != bb[31]) && (o.r[31] != a[31]);
    end else begin
      s = {1'b0, a} + {1'b0, bb};
      o.r = s[31:0];
      v = (a[31] == bb[31]) && (o.r[31] != a[31]);
    end
    o.f = {o.r[31], (o.r == 32'd0), s[32], v};
    return o;
  endfunction

  alu_res_t env_res;
  assign env_res          = alu_fn(bus.alu_op, bus.alu_in0, bus.alu_in1);
  assign bus.alu_out      = env_res.r;
  assign bus.alu_n        = env_res.f[3];
  assign bus.alu_zero     = env_res.f[2];
  assign bus.alu_carryout = env_res.f[1];
  assign bus.alu_overflow = env_res.f[0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  logic [3:0]  last_op;
  logic [31:0] last_in0, last_in1;
  logic [3:0]  last_flags;
  logic [31:0] last_data;
  bit          exp_trap;

  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input bit early);
    alu_res_t e;
    bit       legal;
    legal = (op[3:2] == 2'b00);
    @(negedge clk);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.rsp_ready = early;
    @(negedge clk);
    // junk on the command bus while not ready must be ignored
    bus.cmd_op = 4'($urandom);
    bus.cmd_a  = $urandom;
    bus.cmd_b  = $urandom;
    if (legal) begin
      e = alu_fn(op, a, b);
      last_op  = op;
      last_in0 = a;
      last_in1 = b;
      chk("issue_alu_op", bus.alu_op, op);
      chk("issue_alu_in0", bus.alu_in0, a);
      chk("issue_alu_in1", bus.alu_in1, b);
      chk("issue_rsp_valid", bus.rsp_valid, 0);
      chk("issue_cmd_ready", bus.cmd_ready, 0);
      @(negedge clk);
    end else begin
      e.r = 32'd0;
      e.f = 4'd0;
      chk("illegal_alu_op_hold", bus.alu_op, last_op);
    end
    bus.cmd_valid = 1'b0;
`ifdef ALU_OVF_TRAP_EN
    if (legal && e.f[0]) exp_trap = 1'b1;
`endif
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_data", bus.rsp_data, e.r);
    chk("rsp_flags", bus.rsp_flags, e.f);
    chk("rsp_err", bus.rsp_err, !legal);
    chk("rsp_cmd_ready", bus.cmd_ready, 0);
    chk("rsp_trap", bus.trap, exp_trap);
    last_flags = bus.rsp_flags;
    last_data  = bus.rsp_data;
    if (!early) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_rsp_valid", bus.rsp_valid, 1);
        chk("stall_rsp_data", bus.rsp_data, e.r);
        chk("stall_cmd_ready", bus.cmd_ready, 0);
      end
      bus.rsp_ready = 1'b1;
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_cmd_ready", bus.cmd_ready, !exp_trap);
    chk("post_trap", bus.trap, exp_trap);
    if (exp_trap) begin
      bus.trap_clr = 1'b1;
      @(negedge clk);
      bus.trap_clr = 1'b0;
      exp_trap = 1'b0;
      chk("trapclr_trap", bus.trap, 0);
      chk("trapclr_cmd_ready", bus.cmd_ready, 1);
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'd0;
    bus.cmd_a     = 32'd0;
    bus.cmd_b     = 32'd0;
    bus.rsp_ready = 1'b0;
    bus.trap_clr  = 1'b0;
    last_op       = 4'd0;
    last_in0      = 32'd0;
    last_in1      = 32'd0;
    exp_trap      = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    chk("reset_rsp_flags", bus.rsp_flags, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_alu_in0", bus.alu_in0, 0);
    chk("reset_alu_in1", bus.alu_in1, 0);
    chk("reset_alu_op", bus.alu_op, 0);
    chk("reset_trap", bus.trap, 0);
    rst = 1'b0;

    // directed cases
    run_cmd(4'b0000, 32'd5, 32'd7, 0, 1'b0);
    chk("t1_add_data", last_data, 32'd12);
    run_cmd(4'b0010, 32'h10, 32'h10, 1, 1'b0);
    chk("t2_sub_zero", last_flags[2], 1);
    run_cmd(4'b0101, 32'h1234, 32'h5678, 0, 1'b0);
    run_cmd(4'b0001, 32'hFFFF_FFFF, 32'hAAAA_5555, 5, 1'b0);
    chk("t4_add1_data", last_data, 32'd0);

    // reset while in ISSUE
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'b0000;
    bus.cmd_a     = 32'd9;
    bus.cmd_b     = 32'd3;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    chk("t5_in_issue", bus.alu_op, 0);
    chk("t5_in_issue_in0", bus.alu_in0, 9);
    rst = 1'b1;
    #1;
    chk("t5_rst_rsp_valid", bus.rsp_valid, 0);
    chk("t5_rst_cmd_ready", bus.cmd_ready, 1);
    chk("t5_rst_alu_in0", bus.alu_in0, 0);
    chk("t5_rst_rsp_data", bus.rsp_data, 0);
    @(negedge clk);
    rst = 1'b0;
    last_op  = 4'd0;
    last_in0 = 32'd0;
    last_in1 = 32'd0;
    exp_trap = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_rsp", bus.rsp_valid, 0);
    end
    bus.rsp_ready = 1'b0;

    // signed overflow
    run_cmd(4'b0000, 32'h7FFF_FFFF, 32'd1, 0, 1'b0);
    chk("t6_ovf_flag", last_flags[0], 1);

    // early ready on both legal and illegal commands
    run_cmd(4'b0011, 32'h8000_0000, 32'd0, 0, 1'b1);
    run_cmd(4'b1111, 32'd1, 32'd2, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] op;
      if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(4, 15));
      else                           op = 4'($urandom_range(0, 3));
      run_cmd(op, pick_val(), pick_val(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Command sequencer for the 32-bit add/sub ALU (ops add, add1, sub, sub1).
- Accepts operation requests over a valid/ready command channel and registers the operands and opcode.
- Drives the combinational ALU for one cycle, then captures its result and flags (N, Z, C, V).
- Returns the captured result over a valid/ready response channel.
- Sits between the datapath control and the ALU, so the ALU outputs become a registered, flow-controlled interface.

## Interface
Parameters:
- `W`, 32, operand/result width (ALU is 32-bit; other values unsupported).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_op` in 4: opcode.
  - 0000 add; 0001 add1; 0010 sub; 0011 sub1.
  - Other values are illegal.
- `cmd_a`, `cmd_b` in W: operands.
  - `cmd_b` is ignored for add1 and sub1.
- `alu_in0`, `alu_in1` out W: ALU operands.
- `alu_op` out 4: ALU opcode.
- `alu_out` in W: ALU result.
- `alu_carryout`, `alu_overflow`, `alu_zero`, `alu_n` in 1: ALU flags.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out W: captured result.
- `rsp_flags` out 4: {N,Z,C,V}.
- `rsp_err` out 1: the command carried an illegal opcode.
- `trap` out 1: sticky overflow trap. Present only with `ALU_OVF_TRAP_EN`; otherwise tied to 0.
- `trap_clr` in 1: clears `trap`. Ignored without the macro.

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`, latch `cmd_op`, `cmd_a`, `cmd_b`.
  - Legal op -> ISSUE.
  - Illegal op -> RESP directly with `rsp_err`=1, `rsp_data`=0, `rsp_flags`=0. The ALU is not issued.
- ISSUE:
  - `alu_in0`/`alu_in1`/`alu_op` are driven from the latched registers.
  - At the end of the cycle, capture `alu_out` into `rsp_data`.
  - Capture the flags into `rsp_flags`: N=`alu_n`, Z=`alu_zero`, C=`alu_carryout`, V=`alu_overflow`.
  - Set `rsp_err`=0 and go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_data`, `rsp_flags` and `rsp_err` are held stable.
  - On `rsp_ready`=1 -> IDLE.
  - `cmd_ready`=0 throughout.
- ALU drive registers hold their last values outside ISSUE. The ALU is combinational, so only the ISSUE-cycle values matter.
- The sequencer performs no arithmetic. Results and flags are exactly what the ALU returns.

## Timing
- Reset:
  - state=IDLE.
  - `cmd_ready`=1, `rsp_valid`=0.
  - `rsp_data`=0, `rsp_flags`=0, `rsp_err`=0.
  - `alu_in0`=`alu_in1`=0, `alu_op`=0000, `trap`=0.
- Legal command, measured from the command handshake in cycle T:
  - T+1 is ISSUE.
  - `rsp_valid` rises at the start of T+2.
  - Latency is 2 cycles to response.
- Illegal command: `rsp_valid` at T+1.
- Minimum spacing between legal commands is 3 cycles: handshake in IDLE, ISSUE, RESP with `rsp_ready`=1.
- Response handshake in cycle R: IDLE in cycle R+1. No command is accepted in cycle R.
- `cmd_*` changes while `cmd_ready`=0 have no effect.
- `rsp_ready` held high before `rsp_valid` is allowed; the response still remains valid for one full cycle.
- Reset mid-operation (ISSUE or RESP) discards the command and the response. All outputs return to their reset values immediately (asynchronous).

## Configuration
- Macro: `ALU_OVF_TRAP_EN`.
- Defined:
  - Capturing V=1 in ISSUE sets `trap` in the same edge as the capture.
  - While `trap`=1, `cmd_ready` is forced to 0 in IDLE. The pending response is still delivered normally.
  - `trap_clr`=1 for one cycle clears `trap` at the next edge.
  - If a set and a clear occur in the same cycle, the set wins.
- Undefined:
  - `trap` is tied to 0 and `trap_clr` is unused.
  - Overflow is reported only in `rsp_flags[0]`.

## Test plan
Bench drives the ports from a behavioural ALU model.
1. Add: `cmd_op`=0000, a=5, b=7.
   - Expect `alu_op`=0000 in T+1.
   - Expect `rsp_valid` at T+2 with `rsp_data`=12, `rsp_err`=0.
   - Expect `rsp_flags` equal to the model's flags.
2. Sub equal operands: `cmd_op`=0010, a=b=0x0000_0010.
   - Expect Z=1 in `rsp_flags`.
   - Expect `rsp_data` equal to the model output.
3. Illegal op: `cmd_op`=0101.
   - Expect `rsp_valid` at T+1 with `rsp_err`=1, `rsp_data`=0, `rsp_flags`=0.
   - Expect `alu_op` unchanged from its previous value.
4. Backpressure: hold `rsp_ready`=0 for 5 cycles after an add1 with a=0xFFFF_FFFF.
   - Expect `rsp_valid` and `rsp_data` stable and `cmd_ready`=0 throughout.
   - Expect IDLE the cycle after `rsp_ready`=1.
5. Reset in ISSUE: assert `rst` mid-cycle.
   - Expect `rsp_valid`=0 and `cmd_ready`=1 immediately.
   - Expect no response after release.
6. With `ALU_OVF_TRAP_EN`: add with a=0x7FFF_FFFF, b=1, model V=1.
   - Expect `trap`=1 and `cmd_ready`=0 after the response handshake.
   - Pulse `trap_clr`; expect `trap`=0 and `cmd_ready`=1 next cycle.
